scoreboard: RTL and testbench

//  Tracks in-flight register producers/readers for the Stage-3 dual-issue pipeline.
//  - Produces per-slot hazard flags (RAW/WAW/WAR/load-use) consumed by issue_unit.
//  - Updated from issue_unit grants and the two writeback ports.
//  - Covers older in-flight instructions only; ID0-vs-ID1 intra-pair checks stay in issue_unit.

---
 rtl/scoreboard_pkg.sv | 33 +++
 rtl/scoreboard_if.sv | 58 +++++
 rtl/scoreboard_updown_cnt.sv | 74 +++++++
 rtl/scoreboard.sv | 145 ++++++++++++++
 tb/tb_scoreboard.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scoreboard_pkg.sv
// ============================================================================
// Module : scoreboard_pkg
// Brief  : Shared types and sizes for the dual-issue register scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package scoreboard_pkg;

   localparam int NUM_ARCH_REGS = 32;
   localparam int REG_W         = 5;
   localparam int SB_CNT_W      = 2;

   typedef logic [REG_W-1:0] reg_idx_t;

   typedef struct packed {
      logic [SB_CNT_W-1:0] pend;
      logic                ld;
      logic [SB_CNT_W-1:0] rd_pend;
   } sb_entry_t;

   typedef struct packed {
      reg_idx_t rs1;
      reg_idx_t rs2;
      reg_idx_t rd;
      logic     use_rs1;
      logic     use_rs2;
      logic     we;
   } sb_query_t;

endpackage

`default_nettype wire

// File: rtl/scoreboard_if.sv
// ============================================================================
// Module : scoreboard_if
// Brief  : Query, issue, writeback and hazard signals between issue_unit and scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface scoreboard_if;
   import scoreboard_pkg::*;

   reg_idx_t q0_rs1, q0_rs2, q0_rd;
   reg_idx_t q1_rs1, q1_rs2, q1_rd;
   logic     q0_use_rs1, q0_use_rs2, q0_we;
   logic     q1_use_rs1, q1_use_rs2, q1_we;

   logic     iss0, iss0_is_load, iss0_is_store;
   logic     iss1, iss1_is_load, iss1_is_store;

   logic     wb0_valid, wb0_is_load;
   logic     wb1_valid, wb1_is_load;
   reg_idx_t wb0_rd, wb1_rd;

   logic     st_done;
   reg_idx_t st_done_rs2;
   logic     flush;

   logic     raw_hazard0, raw_hazard1;
   logic     waw_hazard0, waw_hazard1;
   logic     war_hazard0, war_hazard1;
   logic     load_use0, load_use1;

   modport master (
      output q0_rs1, q0_rs2, q0_rd, q0_use_rs1, q0_use_rs2, q0_we,
      output q1_rs1, q1_rs2, q1_rd, q1_use_rs1, q1_use_rs2, q1_we,
      output iss0, iss0_is_load, iss0_is_store,
      output iss1, iss1_is_load, iss1_is_store,
      output wb0_valid, wb0_rd, wb0_is_load,
      output wb1_valid, wb1_rd, wb1_is_load,
      output st_done, st_done_rs2, flush,
      input  raw_hazard0, raw_hazard1, waw_hazard0, waw_hazard1,
      input  war_hazard0, war_hazard1, load_use0, load_use1
   );

   modport slave (
      input  q0_rs1, q0_rs2, q0_rd, q0_use_rs1, q0_use_rs2, q0_we,
      input  q1_rs1, q1_rs2, q1_rd, q1_use_rs1, q1_use_rs2, q1_we,
      input  iss0, iss0_is_load, iss0_is_store,
      input  iss1, iss1_is_load, iss1_is_store,
      input  wb0_valid, wb0_rd, wb0_is_load,
      input  wb1_valid, wb1_rd, wb1_is_load,
      input  st_done, st_done_rs2, flush,
      output raw_hazard0, raw_hazard1, waw_hazard0, waw_hazard1,
      output war_hazard0, war_hazard1, load_use0, load_use1
   );

endinterface

`default_nettype wire

// File: rtl/scoreboard_updown_cnt.sv
// ============================================================================
// Module : sb_updown_cnt
// Brief  : Clamping up/down counter with two increment and two decrement inputs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sb_updown_cnt #(
   parameter int CNT_W = 2
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             clr,
   input  wire logic             inc0,
   input  wire logic             inc1,
   input  wire logic             dec0,
   input  wire logic             dec1,
   output logic [CNT_W-1:0]      cnt_q
);

   localparam int W    = CNT_W + 2;
   localparam int MAXV = (1 << CNT_W) - 1;

   logic [CNT_W-1:0] cnt_d;
   logic [W-1:0]     up;
   logic [W-1:0]     dn;
   logic [W-1:0]     diff;
   logic             overflow;
   logic             underflow;

   // Net change is resolved first so a simultaneous +1/-1 at max stays at max.
   always_comb begin
      up        = {2'b00, cnt_q} + W'(inc0) + W'(inc1);
      dn        = W'(dec0) + W'(dec1);
      diff      = '0;
      cnt_d     = cnt_q;
      overflow  = 1'b0;
      underflow = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (dn > up) begin
         cnt_d     = '0;
         underflow = 1'b1;
      end else begin
         diff = up - dn;
         if (diff > W'(MAXV)) begin
            cnt_d    = '1;
            overflow = 1'b1;
         end else begin
            cnt_d = diff[CNT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!overflow)  else $error("sb_updown_cnt: increment dropped at max");
         assert (!underflow) else $error("sb_updown_cnt: decrement ignored at zero");
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/scoreboard.sv
// ============================================================================
// Module : scoreboard
// Brief  : In-flight producer/reader tracking and per-slot hazard flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module scoreboard
   import scoreboard_pkg::*;
#(
   parameter int NREGS     = NUM_ARCH_REGS,
   parameter int CNT_W     = SB_CNT_W,
   parameter bit WB_BYPASS = 1'b1
) (
   input wire logic    clk,
   input wire logic    rst_n,
   scoreboard_if.slave sb
);

   localparam int CW1 = CNT_W + 1;

   logic [NREGS-1:1] inc_p0, inc_p1, dec_p0, dec_p1;
   logic [NREGS-1:1] inc_r0, inc_r1, dec_r;
   logic [NREGS-1:1] ld_q, ld_d;
   logic [CNT_W-1:0] pend_q    [1:NREGS-1];
   logic [CNT_W-1:0] rd_pend_q [1:NREGS-1];
   logic [NREGS-1:0] busy;
   sb_entry_t        ent [NREGS];
   sb_query_t        qry [2];
   logic [1:0]       raw_v, waw_v, war_v, lu_v;

   // Register 0 never matches, which keeps x0 out of every counter.
   always_comb begin
      inc_p0 = '0; inc_p1 = '0; dec_p0 = '0; dec_p1 = '0;
      inc_r0 = '0; inc_r1 = '0; dec_r  = '0;
      for (int r = 1; r < NREGS; r++) begin
         inc_p0[r] = sb.iss0 && sb.q0_we && (sb.q0_rd == REG_W'(r));
         inc_p1[r] = sb.iss1 && sb.q1_we && (sb.q1_rd == REG_W'(r));
         dec_p0[r] = sb.wb0_valid && (sb.wb0_rd == REG_W'(r));
         dec_p1[r] = sb.wb1_valid && (sb.wb1_rd == REG_W'(r));
         inc_r0[r] = sb.iss0 && sb.iss0_is_store && sb.q0_use_rs2 && (sb.q0_rs2 == REG_W'(r));
         inc_r1[r] = sb.iss1 && sb.iss1_is_store && sb.q1_use_rs2 && (sb.q1_rs2 == REG_W'(r));
         dec_r[r]  = sb.st_done && (sb.st_done_rs2 == REG_W'(r));
      end
   end

   generate
      for (genvar r = 1; r < NREGS; r++) begin : g_reg
         sb_updown_cnt #(.CNT_W(CNT_W)) u_pend (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (sb.flush),
            .inc0  (inc_p0[r]),
            .inc1  (inc_p1[r]),
            .dec0  (dec_p0[r]),
            .dec1  (dec_p1[r]),
            .cnt_q (pend_q[r])
         );
         sb_updown_cnt #(.CNT_W(CNT_W)) u_rd_pend (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (sb.flush),
            .inc0  (inc_r0[r]),
            .inc1  (inc_r1[r]),
            .dec0  (dec_r[r]),
            .dec1  (1'b0),
            .cnt_q (rd_pend_q[r])
         );
      end
   endgenerate

   // Slot1 is younger, so it decides ld when both slots target the same rd.
   always_comb begin
      ld_d = ld_q;
      if (sb.flush) begin
         ld_d = '0;
      end else begin
         for (int r = 1; r < NREGS; r++) begin
            if (inc_p1[r]) begin
               ld_d[r] = sb.iss1_is_load;
            end else if (inc_p0[r]) begin
               ld_d[r] = sb.iss0_is_load;
            end else if ((dec_p0[r] || dec_p1[r]) &&
                         (pend_q[r] == (CNT_W'(dec_p0[r]) + CNT_W'(dec_p1[r])))) begin
               ld_d[r] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_q <= '0;
      end else begin
         ld_q <= ld_d;
      end
   end

   always_comb begin
      busy   = '0;
      ent[0] = '0;
      for (int r = 1; r < NREGS; r++) begin
         ent[r].pend    = pend_q[r];
         ent[r].ld      = ld_q[r];
         ent[r].rd_pend = rd_pend_q[r];
         if (WB_BYPASS) begin
            busy[r] = {1'b0, pend_q[r]} > (CW1'(dec_p0[r]) + CW1'(dec_p1[r]));
         end else begin
            busy[r] = pend_q[r] != '0;
         end
      end
   end

   always_comb begin
      qry[0] = '{rs1: sb.q0_rs1, rs2: sb.q0_rs2, rd: sb.q0_rd,
                 use_rs1: sb.q0_use_rs1, use_rs2: sb.q0_use_rs2, we: sb.q0_we};
      qry[1] = '{rs1: sb.q1_rs1, rs2: sb.q1_rs2, rd: sb.q1_rd,
                 use_rs1: sb.q1_use_rs1, use_rs2: sb.q1_use_rs2, we: sb.q1_we};
   end

   generate
      for (genvar s = 0; s < 2; s++) begin : g_slot
         logic rs1_hit, rs2_hit, rd_ok;
         assign rs1_hit  = qry[s].use_rs1 && (qry[s].rs1 != '0) && busy[qry[s].rs1];
         assign rs2_hit  = qry[s].use_rs2 && (qry[s].rs2 != '0) && busy[qry[s].rs2];
         assign rd_ok    = qry[s].we && (qry[s].rd != '0);
         assign raw_v[s] = rs1_hit || rs2_hit;
         assign lu_v[s]  = (rs1_hit && ent[qry[s].rs1].ld) || (rs2_hit && ent[qry[s].rs2].ld);
         assign waw_v[s] = rd_ok && (busy[qry[s].rd] || (ent[qry[s].rd].pend == '1));
         assign war_v[s] = rd_ok && (ent[qry[s].rd].rd_pend != '0);
      end
   endgenerate

   assign sb.raw_hazard0 = raw_v[0];
   assign sb.raw_hazard1 = raw_v[1];
   assign sb.waw_hazard0 = waw_v[0];
   assign sb.waw_hazard1 = waw_v[1];
   assign sb.war_hazard0 = war_v[0];
   assign sb.war_hazard1 = war_v[1];
   assign sb.load_use0   = lu_v[0];
   assign sb.load_use1   = lu_v[1];

endmodule

`default_nettype wire

// File: tb/tb_scoreboard.sv
// ============================================================================
// Module : tb_scoreboard
// Brief  : Directed self-checking bench for the register scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_scoreboard;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   scoreboard_if sb_if ();

   scoreboard dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (sb_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_in;
      sb_if.q0_rs1 = '0; sb_if.q0_rs2 = '0; sb_if.q0_rd = '0;
      sb_if.q1_rs1 = '0; sb_if.q1_rs2 = '0; sb_if.q1_rd = '0;
      sb_if.q0_use_rs1 = 0; sb_if.q0_use_rs2 = 0; sb_if.q0_we = 0;
      sb_if.q1_use_rs1 = 0; sb_if.q1_use_rs2 = 0; sb_if.q1_we = 0;
      sb_if.iss0 = 0; sb_if.iss0_is_load = 0; sb_if.iss0_is_store = 0;
      sb_if.iss1 = 0; sb_if.iss1_is_load = 0; sb_if.iss1_is_store = 0;
      sb_if.wb0_valid = 0; sb_if.wb0_rd = '0; sb_if.wb0_is_load = 0;
      sb_if.wb1_valid = 0; sb_if.wb1_rd = '0; sb_if.wb1_is_load = 0;
      sb_if.st_done = 0; sb_if.st_done_rs2 = '0; sb_if.flush = 0;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      clear_in();
      rst_n = 1'b0;
      sb_if.q0_use_rs1 = 1; sb_if.q0_rs1 = 5; sb_if.q0_we = 1; sb_if.q0_rd = 5;
      #1;
      checks++;
      if ({sb_if.raw_hazard0, sb_if.waw_hazard0, sb_if.war_hazard0, sb_if.load_use0} !== 4'b0000) begin
         errors++; $display("FAIL reset_state: got %b want 0000",
            {sb_if.raw_hazard0, sb_if.waw_hazard0, sb_if.war_hazard0, sb_if.load_use0});
      end
      #12 rst_n = 1'b1;
      tick();
      sb_if.iss0 = 1; sb_if.iss1 = 1; sb_if.q1_we = 1; sb_if.q1_rd = 5;
      tick();
      sb_if.iss0 = 0; sb_if.iss1 = 0; sb_if.q1_we = 0;
      #1;
      checks++;
      if ({sb_if.raw_hazard0, sb_if.waw_hazard0} !== 2'b11) begin
         errors++; $display("FAIL pend2_busy: got %b want 11", {sb_if.raw_hazard0, sb_if.waw_hazard0});
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({sb_if.raw_hazard0, sb_if.waw_hazard0} !== 2'b00) begin
         errors++; $display("FAIL async_reset: got %b want 00", {sb_if.raw_hazard0, sb_if.waw_hazard0});
      end
      #1 rst_n = 1'b1;
      tick();
      checks++;
      if ({sb_if.raw_hazard0, sb_if.waw_hazard0} !== 2'b00) begin
         errors++; $display("FAIL post_reset: got %b want 00", {sb_if.raw_hazard0, sb_if.waw_hazard0});
      end
      clear_in();
   endtask

   task automatic test_raw_bypass;
      clear_in();
      sb_if.iss0 = 1; sb_if.q0_we = 1; sb_if.q0_rd = 5;
      tick();
      clear_in();
      sb_if.q0_use_rs1 = 1; sb_if.q0_rs1 = 5;
      #1;
      checks++;
      if ({sb_if.raw_hazard0, sb_if.load_use0} !== 2'b10) begin
         errors++; $display("FAIL raw_add: got %b want 10", {sb_if.raw_hazard0, sb_if.load_use0});
      end
      tick();
      checks++;
      if (sb_if.raw_hazard0 !== 1'b1) begin
         errors++; $display("FAIL raw_held: got %b want 1", sb_if.raw_hazard0);
      end
      sb_if.wb0_valid = 1; sb_if.wb0_rd = 5;
      #1;
      checks++;
      if (sb_if.raw_hazard0 !== 1'b0) begin
         errors++; $display("FAIL raw_wb_bypass: got %b want 0", sb_if.raw_hazard0);
      end
      tick();
      sb_if.wb0_valid = 0;
      #1;
      checks++;
      if (sb_if.raw_hazard0 !== 1'b0) begin
         errors++; $display("FAIL raw_after_wb: got %b want 0", sb_if.raw_hazard0);
      end
      clear_in();
   endtask

   task automatic test_load_use;
      clear_in();
      sb_if.iss0 = 1; sb_if.iss0_is_load = 1; sb_if.q0_we = 1; sb_if.q0_rd = 6;
      tick();
      clear_in();
      sb_if.q1_use_rs2 = 1; sb_if.q1_rs2 = 6;
      #1;
      checks++;
      if ({sb_if.raw_hazard1, sb_if.load_use1, sb_if.raw_hazard0} !== 3'b110) begin
         errors++; $display("FAIL load_use_lw: got %b want 110",
            {sb_if.raw_hazard1, sb_if.load_use1, sb_if.raw_hazard0});
      end
      sb_if.wb1_valid = 1; sb_if.wb1_rd = 6; sb_if.wb1_is_load = 1;
      #1;
      checks++;
      if ({sb_if.raw_hazard1, sb_if.load_use1} !== 2'b00) begin
         errors++; $display("FAIL load_use_wb: got %b want 00", {sb_if.raw_hazard1, sb_if.load_use1});
      end
      tick();
      clear_in();
      // slot0 load, slot1 add on x10: youngest is not a load
      sb_if.iss0 = 1; sb_if.iss0_is_load = 1; sb_if.q0_we = 1; sb_if.q0_rd = 10;
      sb_if.iss1 = 1; sb_if.q1_we = 1; sb_if.q1_rd = 10;
      tick();
      clear_in();
      sb_if.q0_use_rs1 = 1; sb_if.q0_rs1 = 10;
      #1;
      checks++;
      if ({sb_if.raw_hazard0, sb_if.load_use0} !== 2'b10) begin
         errors++; $display("FAIL ld_slot1_add: got %b want 10", {sb_if.raw_hazard0, sb_if.load_use0});
      end
      sb_if.iss0 = 1; sb_if.q0_we = 1; sb_if.q0_rd = 11;
      sb_if.iss1 = 1; sb_if.iss1_is_load = 1; sb_if.q1_we = 1; sb_if.q1_rd = 11;
      sb_if.wb0_valid = 1; sb_if.wb0_rd = 10; sb_if.wb1_valid = 1; sb_if.wb1_rd = 10;
      tick();
      clear_in();
      sb_if.q0_use_rs1 = 1; sb_if.q0_rs1 = 10;
      sb_if.q1_use_rs1 = 1; sb_if.q1_rs1 = 11;
      #1;
      checks++;
      if ({sb_if.raw_hazard0, sb_if.raw_hazard1, sb_if.load_use1} !== 3'b011) begin
         errors++; $display("FAIL ld_slot1_lw: got %b want 011",
            {sb_if.raw_hazard0, sb_if.raw_hazard1, sb_if.load_use1});
      end
      sb_if.wb0_valid = 1; sb_if.wb0_rd = 11;
      tick();
      sb_if.wb0_valid = 0;
      #1;
      checks++;
      if ({sb_if.raw_hazard1, sb_if.load_use1} !== 2'b11) begin
         errors++; $display("FAIL ld_held_partial_wb: got %b want 11", {sb_if.raw_hazard1, sb_if.load_use1});
      end
      sb_if.wb0_valid = 1; sb_if.wb0_rd = 11;
      tick();
      clear_in();
   endtask

   task automatic test_waw_same_cycle;
      clear_in();
      sb_if.iss0 = 1; sb_if.q0_we = 1; sb_if.q0_rd = 7;
      tick();
      sb_if.iss0 = 0;
      #1;
      checks++;
      if (sb_if.waw_hazard0 !== 1'b1) begin
         errors++; $display("FAIL waw_pend1: got %b want 1", sb_if.waw_hazard0);
      end
      sb_if.iss0 = 1; sb_if.wb0_valid = 1; sb_if.wb0_rd = 7;
      tick();
      sb_if.iss0 = 0; sb_if.wb0_valid = 0;
      #1;
      checks++;
      if (sb_if.waw_hazard0 !== 1'b1) begin
         errors++; $display("FAIL waw_inc_dec_hold: got %b want 1", sb_if.waw_hazard0);
      end
      sb_if.wb0_valid = 1; sb_if.wb0_rd = 7;
      tick();
      sb_if.wb0_valid = 0;
      #1;
      checks++;
      if (sb_if.waw_hazard0 !== 1'b0) begin
         errors++; $display("FAIL waw_cleared: got %b want 0", sb_if.waw_hazard0);
      end
      clear_in();
   endtask

   task automatic test_war;
      clear_in();
      sb_if.iss0 = 1; sb_if.iss0_is_store = 1; sb_if.q0_use_rs2 = 1; sb_if.q0_rs2 = 8;
      tick();
      clear_in();
      sb_if.q0_we = 1; sb_if.q0_rd = 8;
      #1;
      checks++;
      if ({sb_if.war_hazard0, sb_if.waw_hazard0} !== 2'b10) begin
         errors++; $display("FAIL war_store: got %b want 10", {sb_if.war_hazard0, sb_if.waw_hazard0});
      end
      sb_if.st_done = 1; sb_if.st_done_rs2 = 8;
      #1;
      checks++;
      if (sb_if.war_hazard0 !== 1'b1) begin
         errors++; $display("FAIL war_st_done_cycle: got %b want 1", sb_if.war_hazard0);
      end
      tick();
      sb_if.st_done = 0;
      #1;
      checks++;
      if (sb_if.war_hazard0 !== 1'b0) begin
         errors++; $display("FAIL war_cleared: got %b want 0", sb_if.war_hazard0);
      end
      clear_in();
      sb_if.iss1 = 1; sb_if.iss1_is_store = 1; sb_if.q1_use_rs2 = 1; sb_if.q1_rs2 = 8;
      tick();
      clear_in();
      sb_if.q1_we = 1; sb_if.q1_rd = 8;
      #1;
      checks++;
      if (sb_if.war_hazard1 !== 1'b1) begin
         errors++; $display("FAIL war_slot1: got %b want 1", sb_if.war_hazard1);
      end
      sb_if.st_done = 1; sb_if.st_done_rs2 = 8;
      tick();
      clear_in();
      sb_if.iss0 = 1; sb_if.q0_we = 1; sb_if.q0_rd = 0;
      sb_if.iss1 = 1; sb_if.iss1_is_store = 1; sb_if.q1_use_rs2 = 1; sb_if.q1_rs2 = 0;
      tick();
      clear_in();
      sb_if.q0_we = 1; sb_if.q0_use_rs1 = 1; sb_if.q0_use_rs2 = 1;
      #1;
      checks++;
      if ({sb_if.raw_hazard0, sb_if.waw_hazard0, sb_if.war_hazard0, sb_if.load_use0} !== 4'b0000) begin
         errors++; $display("FAIL x0_query: got %b want 0000",
            {sb_if.raw_hazard0, sb_if.waw_hazard0, sb_if.war_hazard0, sb_if.load_use0});
      end
      clear_in();
   endtask

   task automatic test_saturate_flush;
      clear_in();
      sb_if.iss0 = 1; sb_if.iss0_is_store = 1; sb_if.q0_use_rs2 = 1; sb_if.q0_rs2 = 12;
      tick();
      clear_in();
      sb_if.iss0 = 1; sb_if.q0_we = 1; sb_if.q0_rd = 9;
      sb_if.iss1 = 1; sb_if.q1_we = 1; sb_if.q1_rd = 9;
      tick();
      sb_if.iss1 = 0; sb_if.q1_we = 0;
      tick();
      sb_if.iss0 = 0;
      sb_if.q1_use_rs1 = 1; sb_if.q1_rs1 = 9; sb_if.q1_we = 1; sb_if.q1_rd = 12;
      #1;
      checks++;
      if ({sb_if.waw_hazard0, sb_if.raw_hazard1, sb_if.war_hazard1} !== 3'b111) begin
         errors++; $display("FAIL sat_pend3: got %b want 111",
            {sb_if.waw_hazard0, sb_if.raw_hazard1, sb_if.war_hazard1});
      end
      sb_if.flush = 1; sb_if.iss0 = 1;
      #1;
      checks++;
      if (sb_if.waw_hazard0 !== 1'b1) begin
         errors++; $display("FAIL flush_cycle_waw: got %b want 1", sb_if.waw_hazard0);
      end
      tick();
      sb_if.flush = 0; sb_if.iss0 = 0;
      #1;
      checks++;
      if ({sb_if.waw_hazard0, sb_if.raw_hazard1, sb_if.war_hazard1} !== 3'b000) begin
         errors++; $display("FAIL after_flush: got %b want 000",
            {sb_if.waw_hazard0, sb_if.raw_hazard1, sb_if.war_hazard1});
      end
      clear_in();
   endtask

   initial begin
      test_reset();
      test_raw_bypass();
      test_load_use();
      test_waw_same_cycle();
      test_war();
      test_saturate_flush();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
